h14tx_sync_tracker: RTL and testbench
=====================================

H14TX_SYNC_TRACKER -- requirements
Module: h14tx_sync_tracker

Interface
REQ-001 Parameter BitWidth, default 11: width of horizontal counters and measurements.
REQ-002 Parameter BitHeight, default 10: width of vertical counters and measurements.
REQ-003 Port clk  input  1  pixel clock; the single clock of the block.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port hsync  input  1  horizontal sync, active-high, synchronous to clk.
REQ-006 Port vsync  input  1  vertical sync, active-high, synchronous to clk.
REQ-007 Port de  input  1  data enable, active-high, synchronous to clk.
REQ-008 Port x  output  BitWidth  recovered horizontal position.
REQ-009 Port y  output  BitHeight  recovered vertical position.
REQ-010 Port h_total  output  BitWidth  measured clocks per line.
REQ-011 Port v_total  output  BitHeight  measured lines per frame.
REQ-012 Port h_active  output  BitWidth  measured de-high clocks per line.
REQ-013 Port v_active  output  BitHeight  measured lines containing de per frame.
REQ-014 Port locked  output  1  geometry stable for two consecutive frames.

Function
REQ-015 The block SHALL register hsync, vsync and de once, and SHALL detect edges on the registered values; hrise = hsync_q & ~hsync_q2, vrise likewise, defall = ~de_q & de_q2.
REQ-016 On hrise, x SHALL load 0; otherwise x SHALL increment by 1, saturating at all-ones.
REQ-017 On hrise, h_total SHALL latch x+1; at saturation, the latched value is all-ones.
REQ-018 On hrise, y SHALL increment by 1, saturating at all-ones; on vrise, y SHALL load 0, and vrise SHALL take priority over hrise in the same cycle.
REQ-019 On vrise, v_total SHALL latch y+1, saturating; when hrise coincides with vrise, the count includes the current line.
REQ-020 A per-line de counter SHALL count de_q2-high cycles, clear on hrise, and be latched into h_active on defall.
REQ-021 A per-frame line counter SHALL increment once per defall, clear on vrise, and be latched into v_active on vrise.
REQ-022 Lock FSM states: SEARCH, VERIFY, LOCKED; the FSM is evaluated only on vrise.
REQ-023 In SEARCH on vrise: capture the candidate totals and go to VERIFY.
REQ-024 In VERIFY on vrise: if h_total and v_total equal the candidate, go to LOCKED; otherwise recapture the candidate and stay in VERIFY.
REQ-025 In LOCKED on vrise: on mismatch with the candidate, go to SEARCH; otherwise stay in LOCKED.
REQ-026 Any line that differs from the candidate h_total while the FSM is in LOCKED SHALL force SEARCH on that hrise.
REQ-027 Saturation of x or y SHALL force SEARCH immediately.
REQ-028 locked SHALL be 1 exactly while the state is LOCKED.
REQ-029 Latency: x and y lag the raw inputs by 2 clocks, so x==0 on the second clock after hsync rises at the input.
REQ-030 All arithmetic SHALL be unsigned, truncated to the declared width, with no wrap-around (saturate only).

Reset
REQ-031 While rst_n is low, x, y, h_total, v_total, h_active, v_active, the internal counters and candidates, and all sync pipeline flops SHALL be 0, locked SHALL be 0, and the state SHALL be SEARCH.
REQ-032 Reset asserted mid-frame SHALL take effect asynchronously; after release, the first hrise or vrise SHALL be treated as a fresh edge.

Structure
REQ-033 The lock state enumeration SHALL live in the shared h14tx timings package.
REQ-034 The edge detector SHALL be one sub-module, h14tx_edge_detect, instantiated per sync signal; all other logic is flat.

Verification
REQ-035 Drive 720p timing (1650x750, active 1280x720, hsync 40 clocks, vsync 5 lines) for 3 frames -> h_total=1650, v_total=750, h_active=1280, v_active=720; locked rises on the 2nd vrise after the first full frame.
REQ-036 While locked, stretch one line to 1651 clocks -> locked falls at that line's hrise; re-lock occurs after two clean frames.
REQ-037 Hold hsync low for 2100 clocks (BitWidth=11) -> x saturates at 2047 without wrapping and locked=0.
REQ-038 Assert hsync and vsync rising on the same clock -> y=0 and v_total includes the coincident line.
REQ-039 Assert rst_n low mid-frame while locked -> all outputs are 0 and the state is SEARCH immediately; lock returns after two full frames.
REQ-040 Alternate frames of 750 and 749 lines -> locked stays 0 and the FSM toggles between VERIFY recaptures.

Source files
------------

// File: rtl/h14tx_sync_tracker_pkg.sv
// Shared h14tx timing definitions: lock state encoding used by the sync tracker.
package h14tx_sync_tracker_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/h14tx_sync_tracker_edge_detect.sv
// Registers one sync input and flags rising/falling edges on the registered copy.
module h14tx_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall,
  output logic level
);

  logic sig_q;
  logic sig_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      sig_q2 <= 1'b0;
    end else begin
      sig_q  <= sig;
      sig_q2 <= sig_q;
    end
  end

  assign rise  = sig_q & ~sig_q2;
  assign fall  = ~sig_q & sig_q2;
  assign level = sig_q2;

endmodule

// File: rtl/h14tx_sync_tracker.sv
// Recovers pixel position and measures line/frame geometry from hsync/vsync/de,
// declaring lock once the measured totals repeat across consecutive frames.
module h14tx_sync_tracker
  import h14tx_sync_tracker_pkg::*;
#(
  parameter int BitWidth  = 11,
  parameter int BitHeight = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 de,
  output logic [BitWidth-1:0]  x,
  output logic [BitHeight-1:0] y,
  output logic [BitWidth-1:0]  h_total,
  output logic [BitHeight-1:0] v_total,
  output logic [BitWidth-1:0]  h_active,
  output logic [BitHeight-1:0] v_active,
  output logic                 locked
);

  logic hrise, vrise, defall, de_q2;
  logic hfall_unused, vfall_unused, derise_unused;
  logic hlevel_unused, vlevel_unused;

  h14tx_edge_detect u_hsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (hsync),
    .rise  (hrise),
    .fall  (hfall_unused),
    .level (hlevel_unused)
  );

  h14tx_edge_detect u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (vsync),
    .rise  (vrise),
    .fall  (vfall_unused),
    .level (vlevel_unused)
  );

  h14tx_edge_detect u_de_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (de),
    .rise  (derise_unused),
    .fall  (defall),
    .level (de_q2)
  );

  logic [BitWidth-1:0]  x_inc, de_cnt, de_cnt_inc, de_cnt_upd, cand_h;
  logic [BitHeight-1:0] y_inc, line_cnt, line_inc, line_upd, cand_v;
  logic                 x_sat, y_sat, totals_match, capture;
  lock_state_e          state, state_next;

  // Every increment saturates at all-ones; x_inc doubles as the measured line length.
  assign x_sat      = (x == {BitWidth{1'b1}});
  assign y_sat      = (y == {BitHeight{1'b1}});
  assign x_inc      = x_sat ? x : x + BitWidth'(1);
  assign y_inc      = y_sat ? y : y + BitHeight'(1);
  assign de_cnt_inc = (de_cnt == {BitWidth{1'b1}}) ? de_cnt : de_cnt + BitWidth'(1);
  assign de_cnt_upd = de_q2 ? de_cnt_inc : de_cnt;
  assign line_inc   = (line_cnt == {BitHeight{1'b1}}) ? line_cnt : line_cnt + BitHeight'(1);
  assign line_upd   = defall ? line_inc : line_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      h_total  <= '0;
      v_total  <= '0;
      h_active <= '0;
      v_active <= '0;
      de_cnt   <= '0;
      line_cnt <= '0;
      cand_h   <= '0;
      cand_v   <= '0;
    end else begin
      x <= hrise ? '0 : x_inc;
      if (hrise) h_total <= x_inc;
      if (vrise) begin
        y       <= '0;
        v_total <= y_inc;
      end else if (hrise) begin
        y <= y_inc;
      end
      de_cnt <= hrise ? '0 : de_cnt_upd;
      if (defall) h_active <= de_cnt_upd;
      line_cnt <= vrise ? '0 : line_upd;
      if (vrise) v_active <= line_upd;
      if (capture) begin
        cand_h <= h_total;
        cand_v <= v_total;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_next;
  end

  assign totals_match = (h_total == cand_h) && (v_total == cand_v);

  // Frame-rate decisions on vrise; a bad line or a saturated counter drops lock at once.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    if (vrise) begin
      case (state)
        SEARCH: begin
          capture    = 1'b1;
          state_next = VERIFY;
        end
        VERIFY: begin
          if (totals_match) state_next = LOCKED;
          else              capture    = 1'b1;
        end
        LOCKED: begin
          if (!totals_match) state_next = SEARCH;
        end
        default: state_next = SEARCH;
      endcase
    end
    if ((state == LOCKED) && hrise && (x_inc != cand_h)) state_next = SEARCH;
    if (x_sat || y_sat) state_next = SEARCH;
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_h14tx_sync_tracker.sv
// Directed bench for h14tx_sync_tracker: a per-clock vector table for pipeline
// behaviour, then scaled-down frame sequences for lock, loss of lock and saturation.
module tb_h14tx_sync_tracker;

  localparam int BitWidth  = 11;
  localparam int BitHeight = 10;

  // Scaled geometry keeps frames short: 40x12 total, 24x8 active.
  localparam int HT = 40, HS = 4, HA_START = 10, HA = 24;
  localparam int VS = 2, VA_START = 3, VA = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic [BitWidth-1:0]  x, h_total, h_active;
  logic [BitHeight-1:0] y, v_total, v_active;
  logic locked;

  int checks = 0;
  int failures = 0;

  h14tx_sync_tracker #(.BitWidth(BitWidth), .BitHeight(BitHeight)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .x        (x),
    .y        (y),
    .h_total  (h_total),
    .v_total  (v_total),
    .h_active (h_active),
    .v_active (v_active),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic h;
    logic v;
    logic d;
    int   ex;
    int   ey;
    int   eht;
    int   evt;
    int   eha;
    int   eva;
  } vec_t;

  vec_t vecs [16];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
  task automatic applyStimulus(input logic h, input logic v, input logic d);
    @(negedge clk);
    hsync = h;
    vsync = v;
    de    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_x"}, int'(x), 0);
    checkOutput({tag, "_y"}, int'(y), 0);
    checkOutput({tag, "_h_total"}, int'(h_total), 0);
    checkOutput({tag, "_v_total"}, int'(v_total), 0);
    checkOutput({tag, "_h_active"}, int'(h_active), 0);
    checkOutput({tag, "_v_active"}, int'(v_active), 0);
    checkOutput({tag, "_locked"}, int'(locked), 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    de    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic driveLine(input int line, input int len);
    for (int p = 0; p < len; p++)
      applyStimulus(p < HS, line < VS,
                    (line >= VA_START) && (line < VA_START + VA) &&
                    (p >= HA_START) && (p < HA_START + HA));
  endtask

  task automatic driveFrame(input int lines);
    for (int l = 0; l < lines; l++) driveLine(l, HT);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           h     v     d     x  y  ht vt ha va
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 0, 1, 2, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1, 1, 2, 0, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2, 1, 2, 0, 0, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 3, 1, 2, 0, 0, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 0, 0, 4, 2, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1, 0, 4, 2, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2, 0, 4, 2, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 3, 0, 4, 2, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4, 0, 4, 2, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 5, 0, 4, 2, 3, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 6, 0, 4, 2, 3, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 0, 1, 7, 2, 3, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1, 1, 7, 2, 3, 0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 2, 0, 7, 2, 3, 1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 3, 0, 7, 2, 3, 1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkZero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].h, vecs[i].v, vecs[i].d);
      checkOutput($sformatf("vec%0d_x", i), int'(x), vecs[i].ex);
      checkOutput($sformatf("vec%0d_y", i), int'(y), vecs[i].ey);
      checkOutput($sformatf("vec%0d_h_total", i), int'(h_total), vecs[i].eht);
      checkOutput($sformatf("vec%0d_v_total", i), int'(v_total), vecs[i].evt);
      checkOutput($sformatf("vec%0d_h_active", i), int'(h_active), vecs[i].eha);
      checkOutput($sformatf("vec%0d_v_active", i), int'(v_active), vecs[i].eva);
      checkOutput($sformatf("vec%0d_locked", i), int'(locked), 0);
    end

    // Lock acquisition: candidate settles at the 3rd vrise, match on the 4th.
    doReset();
    for (int f = 1; f <= 3; f++) driveFrame(12);
    checkOutput("acq_f3_locked", int'(locked), 0);
    driveFrame(12);
    checkOutput("acq_f4_locked", int'(locked), 1);
    checkOutput("acq_h_total", int'(h_total), HT);
    checkOutput("acq_v_total", int'(v_total), 12);
    checkOutput("acq_h_active", int'(h_active), HA);
    checkOutput("acq_v_active", int'(v_active), VA);

    // One stretched line drops lock at its closing hrise.
    for (int l = 0; l < 5; l++) driveLine(l, HT);
    driveLine(5, HT + 1);
    checkOutput("long_pre_locked", int'(locked), 1);
    driveLine(6, HT);
    checkOutput("long_post_locked", int'(locked), 0);
    checkOutput("long_h_total", int'(h_total), HT + 1);
    for (int l = 7; l < 12; l++) driveLine(l, HT);
    driveFrame(12);
    checkOutput("relock_f1_locked", int'(locked), 0);
    driveFrame(12);
    checkOutput("relock_f2_locked", int'(locked), 1);

    // Asynchronous reset in the middle of a locked frame.
    for (int l = 0; l < 6; l++) driveLine(l, HT);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("midreset");
    doReset();
    for (int f = 1; f <= 3; f++) driveFrame(12);
    checkOutput("rst_relock_f3_locked", int'(locked), 0);
    driveFrame(12);
    checkOutput("rst_relock_f4_locked", int'(locked), 1);

    // Missing hsync: x pins at all-ones and lock is abandoned.
    repeat (2100) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("xsat_x", int'(x), 2047);
    checkOutput("xsat_locked", int'(locked), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("xsat_h_total", int'(h_total), 2047);
    checkOutput("xsat_x_reload", int'(x), 0);

    // Alternating 12/11-line frames never settle on a candidate.
    doReset();
    driveFrame(12);
    driveFrame(11);
    checkOutput("alt_f2_locked", int'(locked), 0);
    checkOutput("alt_f2_v_total", int'(v_total), 12);
    driveFrame(12);
    checkOutput("alt_f3_locked", int'(locked), 0);
    checkOutput("alt_f3_v_total", int'(v_total), 11);
    driveFrame(11);
    checkOutput("alt_f4_locked", int'(locked), 0);
    checkOutput("alt_f4_v_total", int'(v_total), 12);
    driveFrame(12);
    checkOutput("alt_f5_locked", int'(locked), 0);
    checkOutput("alt_f5_v_total", int'(v_total), 11);

    // Missing vsync: y pins at all-ones; coincident hsync/vsync then reloads y.
    for (int l = 0; l < 1030; l++)
      for (int p = 0; p < 8; p++) applyStimulus(p < 2, 1'b0, 1'b0);
    checkOutput("ysat_y", int'(y), 1023);
    checkOutput("ysat_locked", int'(locked), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("coinc_y", int'(y), 0);
    checkOutput("coinc_x", int'(x), 0);
    checkOutput("coinc_v_total", int'(v_total), 1023);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
